// File: rtl/array_serializer.sv
// Word-to-element serializer: captures an N x W word, then streams its
// elements 0..N-1 one per beat with index and last-beat flag.
module array_serializer #(
  parameter int N  = 3,
  parameter int W  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                CLK,
  input  logic                ASYNCRESETN,
  input  logic                I_valid,
  output logic                I_ready,
  input  logic [N-1:0][W-1:0] I,
  output logic                O_valid,
  input  logic                O_ready,
  output logic [W-1:0]        O,
  output logic [IW-1:0]       O_index,
  output logic                O_last
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t               state;
  state_t               state_nxt;
  logic [N-1:0][W-1:0]  data_q;
  logic [IW-1:0]        idx;
  logic                 at_last;
  logic                 load;
  logic                 beat;

  assign at_last = (idx == LAST);
  assign load    = I_valid & I_ready;
  assign beat    = O_valid & O_ready;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (I_valid) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (O_ready && at_last && !I_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // I_ready is the only output with a combinational input path (O_ready)
  always_comb begin
    O_valid = 1'b0;
    I_ready = 1'b0;
    O       = '0;
    O_index = idx;
    O_last  = 1'b0;
    unique case (state)
      IDLE: begin
        I_ready = ASYNCRESETN;
      end
      SEND: begin
        O_valid = 1'b1;
        I_ready = ASYNCRESETN & O_ready & at_last;
        O       = data_q[idx];
        O_last  = at_last;
      end
      default: begin
        O_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      data_q <= '0;
      idx    <= '0;
    end else if (load) begin
      data_q <= I;
      idx    <= '0;
    end else if (beat) begin
      idx <= at_last ? '0 : idx + 1'b1;
    end
  end

endmodule
